// File: rtl/prio_dec_pkg.sv
// Shared types and sizing for the priority-decoder receive path.
package prio_dec_pkg;

  localparam int IDX_W      = 3;
  localparam int LEN_W      = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int OUT_W      = 1 << IDX_W;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [LEN_W-1:0] len;
  } evt_t;

  // One-hot decode of an event index onto the output bus.
  function automatic logic [OUT_W-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [OUT_W-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/prio_dec_fifo.sv
// Small synchronous event queue. A push while full is accepted only when a
// pop happens at the same edge; the caller tracks any dropped pushes.
module prio_dec_fifo
  import prio_dec_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  evt_t             din,
  output evt_t             dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  evt_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Write accepted events into storage.
  // NOTE: the storage array is deliberately not reset; the pointers and count
  // alone decide which entries are valid, so resetting it would only add logic.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at FIFO_DEPTH.
  // NOTE: every register here uses non-blocking assignment so all updates see
  // the pre-edge values, exactly like the flops they model.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tt_um_priority_decoder.sv
// Receive end of the priority-encoder link: captures strobed {index, length}
// events, queues them and replays each as a timed one-hot pulse on uo_out.
// Optional feature macro: PRIO_DEC_SYNC_EN adds a 2-flop input synchronizer.
module tt_um_priority_decoder
  import prio_dec_pkg::*;
(
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  logic [7:0]       ui_s;
  logic             strobe_q;
  logic             evt_fire;
  logic             pop;
  evt_t             evt_in;
  evt_t             evt_out;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;
  state_t           state;
  logic [LEN_W-1:0] hold_cnt;
  logic             unused_ok;

  assign unused_ok = &{1'b0, ena, uio_in};

`ifdef PRIO_DEC_SYNC_EN
  logic [7:0] sync1;
  logic [7:0] sync2;

  // Two-flop synchronizer for an asynchronous source on ui_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ui_in;
      sync2 <= sync1;
    end
  end

  assign ui_s = sync2;
`else
  assign ui_s = ui_in;
`endif

  assign evt_in.idx = ui_s[2:0];
  assign evt_in.len = ui_s[7:4];
  assign evt_fire   = ui_s[3] && !strobe_q;
  assign pop        = (state == IDLE) && !fifo_empty;

  // Strobe history for rising-edge detection; a strobe held across reset
  // release therefore counts as one event at the first edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= ui_s[3];
    end
  end

  // Sticky overflow: an event arrived while full with no pop to make room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (evt_fire && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

  prio_dec_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (evt_fire),
    .pop   (pop),
    .din   (evt_in),
    .dout  (evt_out),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Pulse sequencer: pop, hold the one-hot for len+1 cycles, then one gap cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      uo_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            uo_out   <= onehot(evt_out.idx);
            hold_cnt <= evt_out.len;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            uo_out <= '0;
            state  <= GAP;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          uo_out <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign uio_out = {1'b0, fifo_count, overflow, fifo_empty, fifo_full, (state != IDLE)};
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_priority_decoder.sv
// Self-checking bench for tt_um_priority_decoder. The reference model is a
// timestamped event queue: each queued event becomes a pulse occupying a
// window of cycles, and the decoder is free again a fixed time after it.
module tb_tt_um_priority_decoder;

`ifdef PRIO_DEC_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int tests = 0;
  int fails = 0;

  tt_um_priority_decoder dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    int idx;
    int len;
  } m_evt_t;

  m_evt_t     mq[$];
  int         edge_n;
  int         ready_edge;
  int         act_start;
  int         act_end;
  int         busy_end;
  int         act_idx;
  bit         m_ovf;
  bit         m_prev_strobe;
  logic [7:0] hist0;
  logic [7:0] hist1;
  logic [7:0] prev_uo;
  int         pulses;
  bit         saw_full;

  task automatic model_reset();
    mq.delete();
    edge_n        = 0;
    ready_edge    = 0;
    act_start     = -100;
    act_end       = -100;
    busy_end      = -100;
    act_idx       = 0;
    m_ovf         = 1'b0;
    m_prev_strobe = 1'b0;
    hist0         = 8'h00;
    hist1         = 8'h00;
    prev_uo       = 8'h00;
    pulses        = 0;
    saw_full      = 1'b0;
  endtask

  // One rising edge: what the capture logic sees, then pop, then push.
  task automatic model_edge(input logic [7:0] ui);
    logic [7:0] eff;
    bit         ev;
    bit         popped;
    bit         was_full;
    m_evt_t     e;
    edge_n = edge_n + 1;
    if (LAT == 2) begin
      eff   = hist1;
      hist1 = hist0;
      hist0 = ui;
    end else begin
      eff = ui;
    end
    ev            = eff[3] && !m_prev_strobe;
    m_prev_strobe = eff[3];
    was_full      = (mq.size() == DEPTH);
    popped        = 1'b0;
    if (edge_n >= ready_edge && mq.size() > 0) begin
      e          = mq.pop_front();
      act_idx    = e.idx;
      act_start  = edge_n;
      act_end    = edge_n + e.len;
      busy_end   = edge_n + e.len + 1;
      ready_edge = edge_n + e.len + 3;
      popped     = 1'b1;
    end
    if (ev) begin
      if (!was_full || popped) begin
        e.idx = int'(eff[2:0]);
        e.len = int'(eff[7:4]);
        mq.push_back(e);
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  function automatic logic [7:0] exp_uo();
    if (edge_n >= act_start && edge_n <= act_end) return 8'(1 << act_idx);
    return 8'h00;
  endfunction

  function automatic logic [7:0] exp_uio();
    logic [2:0] c;
    logic       busy;
    c    = 3'(mq.size());
    busy = (edge_n >= act_start) && (edge_n <= busy_end);
    return {1'b0, c, m_ovf, (mq.size() == 0), (mq.size() == DEPTH), busy};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input string tag, input logic [7:0] ui);
    ui_in = ui;
    @(posedge clk);
    model_edge(ui);
    #1;
    check({tag, "/uo"}, uo_out, exp_uo());
    check({tag, "/uio"}, uio_out, exp_uio());
    if (uo_out !== 8'h00 && prev_uo === 8'h00) pulses++;
    if (uio_out[1] === 1'b1) saw_full = 1'b1;
    prev_uo = uo_out;
  endtask

  task automatic apply_reset(input logic [7:0] ui_hold);
    ui_in = ui_hold;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check("rst/uo", uo_out, 8'h00);
    check("rst/uio", uio_out, 8'h04);
    check("rst/oe", uio_oe, 8'hFF);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    ena    = 1'b1;
    uio_in = 8'($urandom);
    ui_in  = 8'h00;
    rst_n  = 1'b1;
    model_reset();
    #2;

    // 1: reset values
    apply_reset(8'h00);

    // 2: single event idx5 L2, strobe released next cycle
    cycle("t2", 8'h2D);
    repeat (8 + LAT) cycle("t2", 8'h25);
    check("t2_pulses", 8'(pulses), 8'd1);

    // 3: strobe held for 10 cycles -> exactly one pulse
    apply_reset(8'h00);
    repeat (10) cycle("t3", 8'h0B);
    repeat (6 + LAT) cycle("t3", 8'h00);
    check("t3_pulses", 8'(pulses), 8'd1);

    // strobe held across reset release counts once at the first edge
    apply_reset(8'h8E);
    repeat (3) cycle("rel", 8'h8E);
    repeat (14 + LAT) cycle("rel", 8'h00);
    check("rel_pulses", 8'(pulses), 8'd1);

    // 4: long pulse, then six max-rate strobes -> fill, overflow, ordered replay
    apply_reset(8'h00);
    cycle("t4", 8'hF8);
    cycle("t4", 8'h00);
    for (int k = 0; k < 6; k++) begin
      cycle("t4", 8'((k << 4) | 8 | (k + 1)));
      cycle("t4", 8'h00);
    end
    check("t4_full_seen", {7'b0, saw_full}, 8'h01);
    repeat (60) cycle("t4", 8'h00);
    check("t4_pulses", 8'(pulses), 8'd5);
    check("t4_ovf_sticky", {7'b0, uio_out[3]}, 8'h01);
    check("t4_count", {5'b0, uio_out[6:4]}, 8'h00);

    // 5: push coinciding with a pop while full -> no overflow, count stays 4
    apply_reset(8'h00);
    cycle("t5", 8'hF8);
    cycle("t5", 8'h00);
    for (int k = 0; k < 4; k++) begin
      cycle("t5", 8'h19 + 8'(k));
      cycle("t5", 8'h00);
    end
    guard = 0;
    while (edge_n + 1 < ready_edge - LAT && guard < 100) begin
      cycle("t5", 8'h00);
      guard++;
    end
    check("t5_align", 8'(guard < 100), 8'h01);
    cycle("t5", 8'h0D);
    repeat (LAT) cycle("t5", 8'h00);
    check("t5_cnt_ovf", {4'b0, uio_out[6:3]}, 8'h08);
    repeat (30) cycle("t5", 8'h00);

    // 6: async reset mid-HOLD clears outputs without a clock edge
    apply_reset(8'h00);
    cycle("t6", 8'hF8);
    repeat (4 + LAT) cycle("t6", 8'h00);
    check("t6_active", uo_out, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_uo", uo_out, 8'h00);
    check("t6_async_uio", uio_out, 8'h04);
    @(negedge clk);
    ui_in = 8'h00;
    rst_n = 1'b1;
    model_reset();
    check("t6_rel_uio", uio_out, 8'h04);
    repeat (4) cycle("t6", 8'h00);

    // randomized traffic against the model
    apply_reset(8'h00);
    for (int i = 0; i < 400; i++) begin
      cycle("rnd", 8'($urandom));
    end
    repeat (100) cycle("rnd_drain", 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
